// File: rtl/sseg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl_pkg
// Shared definitions for the seven-segment scan controller: scan FSM state
// encoding, the all-segments-off code and the hex-to-segment mapping used by
// the shared decoder ROM.
// Segment codes are gfedcba, active-low (common-anode display).
// -----------------------------------------------------------------------------
package sseg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SSEG_OFF = 7'h7F;

  // Hex digit to active-low gfedcba segment pattern
  function automatic logic [6:0] hex2sseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SSEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_bin2sseg_rom.sv
// -----------------------------------------------------------------------------
// bin2sseg_rom
// Registered hex-to-seven-segment decoder, shared by all digits of the scan
// controller. Output is valid one clock after the input nibble is presented.
// Ports:
//   iCLK    clock, rising edge
//   iRST_N  asynchronous active-low reset (output forced to all segments off)
//   iHEX    hex nibble to decode
//   oSSEG   registered gfedcba pattern, active-low
// -----------------------------------------------------------------------------
module bin2sseg_rom (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [3:0] iHEX,
  output logic [6:0] oSSEG
);
  import sseg_scan_ctrl_pkg::*;

  logic [6:0] r_sseg;

  // Decode register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sseg <= SSEG_OFF;
    end else begin
      r_sseg <= hex2sseg(iHEX);
    end
  end

  assign oSSEG = r_sseg;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display. Each digit slot is BLANK (all anodes off), FETCH (shared decoder
// settles) and SHOW (one anode on). New values are taken through a
// ready/load handshake into a pending register and committed to the display
// register only at the end of a full frame.
// Ports:
//   iCLK, iRST_N   clock and asynchronous active-low reset
//   iLOAD          load request, accepted while oREADY=1
//   iVALUE, iDP    hex nibbles / decimal-point enables, index i -> digit i
//   iBLANK_LZ      leading-zero suppression enable (live)
//   oREADY         no load pending
//   oAN, oSSEG,oDP anode selects, segments, decimal point (all active-low)
//   oFRAME         one-cycle pulse at the end of each frame
// DIV_MAX and BLANK_CYC-1 must fit in DIV_W bits.
// -----------------------------------------------------------------------------
module sseg_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int DIV_W     = 16,
  parameter int DIV_MAX   = 49999,
  parameter int BLANK_CYC = 2
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iLOAD,
  input  logic [4*N_DIGITS-1:0] iVALUE,
  input  logic [N_DIGITS-1:0]   iDP,
  input  logic                  iBLANK_LZ,
  output logic                  oREADY,
  output logic [N_DIGITS-1:0]   oAN,
  output logic [6:0]            oSSEG,
  output logic                  oDP,
  output logic                  oFRAME
);
  import sseg_scan_ctrl_pkg::*;

  localparam int                  IDX_W      = $clog2(N_DIGITS);
  localparam logic [DIV_W-1:0]    BLANK_LAST = DIV_W'(BLANK_CYC - 1);
  localparam logic [DIV_W-1:0]    SHOW_LAST  = DIV_W'(DIV_MAX);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF     = {N_DIGITS{1'b1}};
  localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);

  scan_state_t             r_state;
  logic [DIV_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*N_DIGITS-1:0]   r_disp_val;
  logic [N_DIGITS-1:0]     r_disp_dp;
  logic [4*N_DIGITS-1:0]   r_pend_val;
  logic [N_DIGITS-1:0]     r_pend_dp;
  logic                    r_ready;
  logic [N_DIGITS-1:0]     r_an;
  logic [6:0]              r_sseg;
  logic                    r_dp;
  logic                    r_frame;

  logic [3:0]              w_nib;
  logic [6:0]              w_dec;
  logic [N_DIGITS-1:0]     w_zero_from;
  logic [N_DIGITS-1:0]     w_supp_mask;
  logic                    w_supp;
  logic                    w_dp_sel;
  logic                    w_frame_end;

  assign w_nib       = r_disp_val[{r_idx, 2'b00} +: 4];
  assign w_dp_sel    = r_disp_dp[r_idx];
  assign w_supp      = w_supp_mask[r_idx];
  assign w_frame_end = (r_state == ST_SHOW) && (r_cnt == SHOW_LAST) && (r_idx == IDX_LAST);

  bin2sseg_rom u_rom (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iHEX   (w_nib),
    .oSSEG  (w_dec)
  );

  // Leading-zero mask: w_zero_from[i] means nibbles N_DIGITS-1..i are all zero;
  // digit 0 always stays lit.
  always_comb begin
    w_zero_from = '0;
    w_zero_from[N_DIGITS-1] = (r_disp_val[4*N_DIGITS-1 -: 4] == 4'h0);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      w_zero_from[i] = w_zero_from[i+1] & (r_disp_val[4*i +: 4] == 4'h0);
    end
    w_supp_mask    = w_zero_from & {N_DIGITS{iBLANK_LZ}};
    w_supp_mask[0] = 1'b0;
  end

  // Scan FSM with registered display outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_an    <= AN_OFF;
      r_sseg  <= SSEG_OFF;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      case (r_state)
        ST_BLANK: begin
          r_an   <= AN_OFF;
          r_sseg <= SSEG_OFF;
          r_dp   <= 1'b1;
          if (r_cnt == BLANK_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_FETCH;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        ST_FETCH: begin
          // Decoder output now reflects nibble[idx]; light the digit on entry to SHOW
          r_cnt   <= '0;
          r_state <= ST_SHOW;
          r_an    <= ~(AN_ONE << r_idx);
          if (w_supp) begin
            r_sseg <= SSEG_OFF;
            r_dp   <= 1'b1;
          end else begin
            r_sseg <= w_dec;
            r_dp   <= ~w_dp_sel;
          end
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_BLANK;
            r_an    <= AN_OFF;
            r_sseg  <= SSEG_OFF;
            r_dp    <= 1'b1;
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_frame <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_an    <= AN_OFF;
          r_sseg  <= SSEG_OFF;
          r_dp    <= 1'b1;
        end
      endcase
    end
  end

  // Load handshake and frame-boundary commit of pending to display
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_ready    <= 1'b1;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
    end else begin
      if (!r_ready && w_frame_end) begin
        // Commit cycle: r_ready is still 0, so a coincident iLOAD is dropped
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
        r_ready    <= 1'b1;
      end else if (r_ready && iLOAD) begin
        r_pend_val <= iVALUE;
        r_pend_dp  <= iDP;
        r_ready    <= 1'b0;
      end else begin
        r_ready <= r_ready;
      end
    end
  end

  assign oREADY = r_ready;
  assign oAN    = r_an;
  assign oSSEG  = r_sseg;
  assign oDP    = r_dp;
  assign oFRAME = r_frame;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: N_DIGITS=4, DIV_MAX=3, BLANK_CYC=1
// (6 cycles per digit, 24 per frame). Expected digit slots are pushed to a
// queue per frame and popped by a display monitor as each digit lights.
module tb_sseg_scan_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iLOAD = 1'b0;
  logic [15:0] iVALUE = 16'h0000;
  logic [3:0]  iDP = 4'b0000;
  logic        iBLANK_LZ = 1'b0;
  logic        oREADY;
  logic [3:0]  oAN;
  logic [6:0]  oSSEG;
  logic        oDP;
  logic        oFRAME;

  sseg_scan_ctrl #(
    .N_DIGITS  (4),
    .DIV_W     (16),
    .DIV_MAX   (3),
    .BLANK_CYC (1)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iLOAD     (iLOAD),
    .iVALUE    (iVALUE),
    .iDP       (iDP),
    .iBLANK_LZ (iBLANK_LZ),
    .oREADY    (oREADY),
    .oAN       (oAN),
    .oSSEG     (oSSEG),
    .oDP       (oDP),
    .oFRAME    (oFRAME)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } dig_t;

  dig_t       exp_q[$];
  dig_t       mon_d;
  logic [6:0] seg_tab [16];
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev_an = 4'hF;
  int         show_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] value, input logic [3:0] dp, input logic blz);
    for (int i = 0; i < 4; i++) begin
      dig_t        d;
      logic [15:0] upper;
      logic        supp;
      upper   = value >> (4 * i);
      supp    = blz && (i > 0) && (upper == 16'h0000);
      d.an    = 4'hF;
      d.an[i] = 1'b0;
      d.seg   = supp ? 7'h7F : seg_tab[value[4*i +: 4]];
      d.dp    = supp ? 1'b1 : ~dp[i];
      exp_q.push_back(d);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge iCLK); #1;
      n++;
    end while (oFRAME !== 1'b1 && n < 100);
    chk("frame_pulse", {31'd0, oFRAME}, 32'd1);
  endtask

  // Release-from-reset sequence: 2 dark samples, digit 0 showing '0' for 4, then dark
  task automatic startup_check();
    for (int k = 0; k < 7; k++) begin
      if (k >= 2 && k < 6) begin
        chk("start_an", {28'd0, oAN}, {28'd0, 4'b1110});
        chk("start_seg", {24'd0, oSSEG, oDP}, {24'd0, 7'b1000000, 1'b1});
      end else begin
        chk("start_an", {28'd0, oAN}, {28'd0, 4'b1111});
        chk("start_seg", {24'd0, oSSEG, oDP}, {24'd0, 7'h7F, 1'b1});
      end
      chk("start_ready", {31'd0, oREADY}, 32'd1);
      @(negedge iCLK); #1;
    end
  endtask

  // Display monitor: pops one expected slot whenever a digit lights
  initial begin
    forever begin
      @(negedge iCLK);
      if (mon_en) begin
        if (oAN == 4'hF) begin
          if (show_len != 0) begin
            chk("show_len", show_len, 32'd4);
            show_len = 0;
          end
          chk("blank_seg", {24'd0, oSSEG, oDP}, {24'd0, 7'h7F, 1'b1});
        end else if (prev_an == 4'hF) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_digit: got an=%b want no digit", oAN);
          end else begin
            mon_d = exp_q.pop_front();
            chk("digit_an", {28'd0, oAN}, {28'd0, mon_d.an});
            chk("digit_seg", {25'd0, oSSEG}, {25'd0, mon_d.seg});
            chk("digit_dp", {31'd0, oDP}, {31'd0, mon_d.dp});
          end
          show_len = 1;
        end else begin
          show_len++;
        end
      end
      prev_an = oAN;
    end
  end

  initial begin
    vec_t vecs[6];
    vec_t prev;
    int   n;

    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

    vecs[0] = '{16'h12AF, 4'b0000, 1'b0};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1};
    vecs[3] = '{16'h3210, 4'b0100, 1'b0};
    vecs[4] = '{16'h0050, 4'b0000, 1'b0};
    vecs[5] = '{16'h0F00, 4'b1001, 1'b1};

    // Reset values
    repeat (3) @(negedge iCLK);
    #1;
    chk("rst_an", {28'd0, oAN}, {28'd0, 4'hF});
    chk("rst_seg", {25'd0, oSSEG}, {25'd0, 7'h7F});
    chk("rst_dp", {31'd0, oDP}, 32'd1);
    chk("rst_ready", {31'd0, oREADY}, 32'd1);
    chk("rst_frame", {31'd0, oFRAME}, 32'd0);

    @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    startup_check();

    prev = '{16'h0000, 4'b0000, 1'b0};
    for (int v = 0; v < 6; v++) begin
      // Frame with the previously committed value, load issued mid-frame
      wait_frame();
      push_frame(prev.value, prev.dp, prev.blz);
      mon_en = 1'b1;
      repeat (3) @(negedge iCLK);
      #1;
      chk("ready_idle", {31'd0, oREADY}, 32'd1);
      iLOAD  = 1'b1;
      iVALUE = vecs[v].value;
      iDP    = vecs[v].dp;
      @(negedge iCLK); #1;
      // Keep requesting with other data: must be ignored while busy and at commit
      iVALUE = (v == 0) ? 16'h3333 : ~vecs[v].value;
      iDP    = ~vecs[v].dp;
      chk("ready_busy", {31'd0, oREADY}, 32'd0);
      wait_frame();
      iLOAD = 1'b0;
      chk("ready_commit", {31'd0, oREADY}, 32'd1);
      iBLANK_LZ = vecs[v].blz;
      push_frame(vecs[v].value, vecs[v].dp, vecs[v].blz);
      @(negedge iCLK); #1;
      chk("ready_after_commit", {31'd0, oREADY}, 32'd1);
      prev = vecs[v];
    end
    wait_frame();
    chk("queue_drain", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    // Asynchronous reset in the middle of digit 2's SHOW
    n = 0;
    while (oAN !== 4'b1011 && n < 100) begin
      @(negedge iCLK); #1;
      n++;
    end
    chk("reach_digit2", {28'd0, oAN}, {28'd0, 4'b1011});
    @(negedge iCLK);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("async_an", {28'd0, oAN}, {28'd0, 4'hF});
    chk("async_seg", {24'd0, oSSEG, oDP}, {24'd0, 7'h7F, 1'b1});
    chk("async_ready", {31'd0, oREADY}, 32'd1);
    @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    startup_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
